// File: rtl/sopc_bus_pkg.sv
// Shared definitions for the SOPC data-side bus: FSM encoding, error data value
// and the default memory map used by the data bus bridge.
package sopc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } bus_state_e;

  localparam logic [31:0] BUS_ERR_DATA = 32'h0000_0000;

  // Default map: slot 0 = data RAM, slots 1..3 = peripheral windows (64 MiB each)
  localparam int unsigned DEF_NUM_SLAVES = 4;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLV_BASE =
    {32'h1000_0000, 32'h0800_0000, 32'h0400_0000, 32'h0000_0000};
  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLV_MASK =
    {4{32'hFC00_0000}};

  // Timeout counter width: enough to hold TIMEOUT, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address decoder: one-hot window hit with lowest-index priority,
// plus a miss flag when no window matches.
module bus_addr_decoder
  import sopc_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [NUM_SLAVES-1:0] o_hit,
  output logic                  o_miss
);

  logic [NUM_SLAVES-1:0] w_match;

  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_win
    assign w_match[k] =
      ((i_addr & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]);
  end

  // Isolate the lowest set bit so overlapping windows resolve to the lowest index
  assign o_hit  = w_match & (~w_match + NUM_SLAVES'(1));
  assign o_miss = ~|w_match;

endmodule

// File: rtl/sopc_data_bus_bridge.sv
// Data-side bridge from the CPU RAM port to N memory-mapped slaves: decodes,
// strobes the selected slave, stalls the CPU until ack, and returns bus errors
// on unmapped addresses or slave timeout.
module sopc_data_bus_bridge
  import sopc_bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_ce_i,
  input  logic                         m_we_i,
  input  logic [DATA_W/8-1:0]          m_sel_i,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic [DATA_W-1:0]            m_data_i,
  output logic [DATA_W-1:0]            m_data_o,
  output logic                         m_stall_o,
  output logic                         m_err_o,
  output logic [NUM_SLAVES-1:0]        s_ce_o,
  output logic                         s_we_o,
  output logic [DATA_W/8-1:0]          s_sel_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_data_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  bus_state_e            r_state;
  bus_state_e            w_state_nxt;

  logic                  r_we;
  logic [SEL_W-1:0]      r_sel;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [NUM_SLAVES-1:0] r_ce;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;

  logic [NUM_SLAVES-1:0] w_hit;
  logic                  w_miss;
  logic                  w_ack;
  logic                  w_timeout;
  logic [DATA_W-1:0]     w_ack_data;
  logic                  w_latch;
  logic [NUM_SLAVES-1:0] w_ce_nxt;
  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic [DATA_W-1:0]     w_rdata_nxt;
  logic                  w_err_nxt;

  bus_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_dec (
    .i_addr (m_addr_i),
    .o_hit  (w_hit),
    .o_miss (w_miss)
  );

  // r_ce is non-zero only in BUSY, so it also masks out acks from unselected slaves
  assign w_ack     = |(s_ack_i & r_ce);
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_comb begin
    w_ack_data = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (r_ce[k]) begin
        w_ack_data = w_ack_data | s_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_ce_nxt    = '0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_rdata_nxt = '0;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (m_ce_i) begin
          w_latch = 1'b1;
          if (w_miss) begin
            w_state_nxt = ST_DONE;
            w_rdata_nxt = DATA_W'(BUS_ERR_DATA);
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_BUSY;
            w_ce_nxt    = w_hit;
            w_cnt_clr   = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // Ack takes precedence over a timeout landing in the same cycle
        if (w_ack) begin
          w_state_nxt = ST_DONE;
          w_rdata_nxt = w_ack_data;
        end else if (w_timeout) begin
          w_state_nxt = ST_DONE;
          w_rdata_nxt = DATA_W'(BUS_ERR_DATA);
          w_err_nxt   = 1'b1;
        end else begin
          w_ce_nxt  = r_ce;
          w_cnt_inc = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ce    <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_latch) begin
        r_we    <= m_we_i;
        r_sel   <= m_sel_i;
        r_addr  <= m_addr_i;
        r_wdata <= m_data_i;
      end
      r_ce    <= w_ce_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
      // Counter saturates rather than wrapping when the timeout is disabled
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign m_stall_o = m_ce_i && (r_state != ST_DONE);
  assign m_data_o  = r_rdata;
  assign m_err_o   = r_err;
  assign s_ce_o    = r_ce;
  assign s_we_o    = r_we;
  assign s_sel_o   = r_sel;
  assign s_addr_o  = r_addr;
  assign s_data_o  = r_wdata;

endmodule

// File: tb/tb_sopc_data_bus_bridge.sv
// Bench for sopc_data_bus_bridge: transaction-level model of decode, wait,
// timeout and error behaviour, checked against the DUT on every cycle.
`timescale 1ns/1ps
module tb_sopc_data_bus_bridge;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;
  localparam logic [NS*AW-1:0] P_BASE =
    {32'h0400_0000, 32'h0800_0000, 32'h0400_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] P_MASK = {4{32'hFC00_0000}};
  localparam logic [31:0] WIN_MASK = 32'hFC00_0000;

  logic [31:0] win_base [NS] = '{32'h0000_0000, 32'h0400_0000, 32'h0800_0000, 32'h0400_0000};

  logic           clk;
  logic           rst;
  logic           m_ce_i;
  logic           m_we_i;
  logic [3:0]     m_sel_i;
  logic [31:0]    m_addr_i;
  logic [31:0]    m_data_i;
  logic [31:0]    m_data_o;
  logic           m_stall_o;
  logic           m_err_o;
  logic [NS-1:0]  s_ce_o;
  logic           s_we_o;
  logic [3:0]     s_sel_o;
  logic [31:0]    s_addr_o;
  logic [31:0]    s_data_o;
  logic [NS*DW-1:0] s_data_i;
  logic [NS-1:0]  s_ack_i;

  sopc_data_bus_bridge #(
    .NUM_SLAVES (NS),
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .SLV_BASE   (P_BASE),
    .SLV_MASK   (P_MASK),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_ce_i    (m_ce_i),
    .m_we_i    (m_we_i),
    .m_sel_i   (m_sel_i),
    .m_addr_i  (m_addr_i),
    .m_data_i  (m_data_i),
    .m_data_o  (m_data_o),
    .m_stall_o (m_stall_o),
    .m_err_o   (m_err_o),
    .s_ce_o    (s_ce_o),
    .s_we_o    (s_we_o),
    .s_sel_o   (s_sel_o),
    .s_addr_o  (s_addr_o),
    .s_data_o  (s_data_o),
    .s_data_i  (s_data_i),
    .s_ack_i   (s_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_err, exp_we;
  logic [3:0]  exp_ce, exp_sel;
  logic [31:0] exp_data, exp_addr, exp_wdata;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Cycle-by-cycle comparison against the model's expected outputs
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",    32'(m_stall_o), 32'(exp_stall));
      chk("s_ce",     32'(s_ce_o),    32'(exp_ce));
      chk("m_err",    32'(m_err_o),   32'(exp_err));
      chk("m_data",   m_data_o,       exp_data);
      chk("s_we",     32'(s_we_o),    32'(exp_we));
      chk("s_sel",    32'(s_sel_o),   32'(exp_sel));
      chk("s_addr",   s_addr_o,       exp_addr);
      chk("s_wdata",  s_data_o,       exp_wdata);
    end
  end

  function automatic int model_decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++) begin
      if ((a & WIN_MASK) == win_base[k]) return k;
    end
    return -1;
  endfunction

  task automatic rand_bus(input int tgt, input logic tgt_ack, input logic spur);
    s_ack_i  = 4'($urandom);
    s_data_i = {$urandom, $urandom, $urandom, $urandom};
    if (tgt >= 0) begin
      if (spur) s_ack_i = 4'hF;
      s_ack_i[tgt] = tgt_ack;
    end
  endtask

  task automatic rand_cpu_fields();
    m_we_i   = 1'($urandom);
    m_sel_i  = 4'($urandom);
    m_addr_i = $urandom;
    m_data_i = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      m_ce_i = 1'b0;
      rand_cpu_fields();
      rand_bus(-1, 1'b0, 1'b0);
      exp_stall = 1'b0; exp_ce = '0; exp_err = 1'b0; exp_data = '0;
      @(posedge clk); #1;
    end
  endtask

  // One CPU access; lat = wait cycles before ack (ack in BUSY cycle lat+1), -1 = never
  task automatic do_access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat, input logic [31:0] rdata,
                           input logic spur, output int n_stall, output int n_ce,
                           output logic [31:0] got_data, output logic got_err);
    int tgt, nbusy;
    logic e_err;
    logic [31:0] e_data;
    tgt = model_decode(addr);
    if (tgt < 0) begin
      nbusy = 0; e_err = 1'b1; e_data = 32'h0;
    end else if (lat < 0 || lat + 1 > int'(TO)) begin
      nbusy = TO; e_err = 1'b1; e_data = 32'h0;
    end else begin
      nbusy = lat + 1; e_err = 1'b0; e_data = rdata;
    end
    n_stall = 0; n_ce = 0;

    m_ce_i = 1'b1; m_we_i = we; m_sel_i = sel; m_addr_i = addr; m_data_i = wdata;
    rand_bus(-1, 1'b0, 1'b0);
    exp_stall = 1'b1; exp_ce = '0; exp_err = 1'b0; exp_data = '0;
    @(negedge clk);
    if (m_stall_o) n_stall++;
    if (s_ce_o != '0) n_ce++;
    @(posedge clk); #1;
    exp_we = we; exp_sel = sel; exp_addr = addr; exp_wdata = wdata;

    for (int c = 1; c <= nbusy; c++) begin
      rand_cpu_fields();
      rand_bus(tgt, (c == lat + 1), spur);
      if (c == lat + 1) s_data_i[tgt*32 +: 32] = rdata;
      exp_stall = 1'b1; exp_ce = 4'(1 << tgt);
      @(negedge clk);
      if (m_stall_o) n_stall++;
      if (s_ce_o != '0) n_ce++;
      @(posedge clk); #1;
    end

    rand_cpu_fields();
    rand_bus(-1, 1'b0, 1'b0);
    exp_stall = 1'b0; exp_ce = '0; exp_err = e_err; exp_data = e_data;
    @(negedge clk);
    if (m_stall_o) n_stall++;
    got_data = m_data_o;
    got_err  = m_err_o;
    @(posedge clk); #1;
    m_ce_i = 1'b0;
    exp_stall = 1'b0; exp_err = 1'b0; exp_data = '0;
  endtask

  int          ns, nc;
  logic [31:0] gd;
  logic        ge;

  initial begin
    rst = 1'b0;
    m_ce_i = 1'b0; m_we_i = 1'b0; m_sel_i = '0; m_addr_i = '0; m_data_i = '0;
    s_ack_i = '0; s_data_i = '0;
    exp_stall = 1'b0; exp_ce = '0; exp_err = 1'b0; exp_data = '0;
    exp_we = 1'b0; exp_sel = '0; exp_addr = '0; exp_wdata = '0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    m_ce_i = 1'b1; exp_stall = 1'b1;
    @(posedge clk); #1;
    chk("rst_stall_follows_ce", 32'(m_stall_o), 32'd1);
    chk("rst_s_ce", 32'(s_ce_o), 32'd0);
    chk("rst_m_err", 32'(m_err_o), 32'd0);
    chk("rst_m_data", m_data_o, 32'd0);
    m_ce_i = 1'b0; exp_stall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // Minimum-latency read from slave 0
    do_access(1'b0, 4'hF, 32'h0000_0040, 32'h0, 0, 32'hCAFE_F00D, 1'b0, ns, nc, gd, ge);
    chk("rd0_stall_cycles", 32'(ns), 32'd2);
    chk("rd0_data", gd, 32'hCAFE_F00D);
    chk("rd0_err", 32'(ge), 32'd0);
    idle(1);

    // Write to slave 1 with three wait cycles
    do_access(1'b1, 4'b0011, 32'h0400_0010, 32'h1234_5678, 3, 32'h0, 1'b0, ns, nc, gd, ge);
    chk("wr1_ce_cycles", 32'(nc), 32'd4);
    chk("wr1_stall_cycles", 32'(ns), 32'd5);
    chk("wr1_err", 32'(ge), 32'd0);
    chk("wr1_s_data_held", s_data_o, 32'h1234_5678);
    chk("wr1_s_sel_held", 32'(s_sel_o), 32'h3);
    idle(1);

    // Unmapped address
    do_access(1'b0, 4'hF, 32'hF000_0000, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, ns, nc, gd, ge);
    chk("miss_ce_cycles", 32'(nc), 32'd0);
    chk("miss_stall_cycles", 32'(ns), 32'd1);
    chk("miss_err", 32'(ge), 32'd1);
    chk("miss_data", gd, 32'd0);

    // Slave 2 never acks, then acks exactly in the last BUSY cycle
    do_access(1'b0, 4'hF, 32'h0800_0000, 32'h0, -1, 32'h0, 1'b0, ns, nc, gd, ge);
    chk("to_busy_cycles", 32'(nc), 32'd4);
    chk("to_err", 32'(ge), 32'd1);
    chk("to_data", gd, 32'd0);
    do_access(1'b0, 4'hF, 32'h0800_0004, 32'h0, 3, 32'hA5A5_0002, 1'b0, ns, nc, gd, ge);
    chk("to_edge_err", 32'(ge), 32'd0);
    chk("to_edge_data", gd, 32'hA5A5_0002);

    // Overlapping windows 1 and 3 with every other slave acking spuriously
    do_access(1'b0, 4'hF, 32'h0400_0000, 32'h0, 2, 32'h0BAD_F00D, 1'b1, ns, nc, gd, ge);
    chk("ovl_ce_cycles", 32'(nc), 32'd3);
    chk("ovl_err", 32'(ge), 32'd0);
    chk("ovl_data", gd, 32'h0BAD_F00D);
    idle(1);

    // Reset asserted in the middle of BUSY
    m_ce_i = 1'b1; m_we_i = 1'b1; m_sel_i = 4'hF; m_addr_i = 32'h0800_0200; m_data_i = 32'h7777_0000;
    rand_bus(-1, 1'b0, 1'b0);
    exp_stall = 1'b1;
    @(posedge clk); #1;
    exp_we = 1'b1; exp_sel = 4'hF; exp_addr = 32'h0800_0200; exp_wdata = 32'h7777_0000;
    exp_ce = 4'b0100;
    rand_bus(2, 1'b0, 1'b0);
    @(posedge clk); #1;
    rand_bus(2, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    exp_ce = '0; exp_we = 1'b0; exp_sel = '0; exp_addr = '0; exp_wdata = '0;
    #1;
    chk("rstmid_s_ce", 32'(s_ce_o), 32'd0);
    chk("rstmid_m_err", 32'(m_err_o), 32'd0);
    chk("rstmid_stall", 32'(m_stall_o), 32'd1);
    chk("rstmid_s_addr", s_addr_o, 32'd0);
    @(posedge clk); #1;
    m_ce_i = 1'b0; exp_stall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    do_access(1'b0, 4'hF, 32'h0000_0100, 32'h0, 1, 32'h600D_BEEF, 1'b0, ns, nc, gd, ge);
    chk("post_rst_stall_cycles", 32'(ns), 32'd3);
    chk("post_rst_data", gd, 32'h600D_BEEF);
    chk("post_rst_err", 32'(ge), 32'd0);

    // Randomised traffic over hits, overlaps, misses, waits and timeouts
    for (int t = 0; t < 80; t++) begin
      int sel_win, lat;
      logic [31:0] a;
      sel_win = int'($urandom_range(0, 4));
      if (sel_win < int'(NS)) a = win_base[sel_win] | ($urandom & ~WIN_MASK);
      else a = $urandom;
      lat = int'($urandom_range(0, 6));
      if (lat == 6) lat = -1;
      do_access(1'($urandom), 4'($urandom), a, $urandom, lat, $urandom,
                1'($urandom), ns, nc, gd, ge);
      idle(int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
